// File: rtl/e3_serial_addsub.sv
// e3_serial_addsub: digit-serial Excess-3 adder/subtractor, LSD first, sign+magnitude result.
// A negative difference is re-complemented in a second serial pass (FIX).
module e3_serial_addsub #(
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  sub,
    input  logic [4*DIGITS-1:0]   in_1,
    input  logic [4*DIGITS-1:0]   in_2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS+3:0]   out_1,
    output logic                  neg,
    output logic                  err
);
    localparam int CW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam int W  = 4 * DIGITS;

    typedef enum logic [1:0] {IDLE, ADD, FIX, DONE} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d;
    logic [W+3:0]    res_q, res_d, sh;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            sub_q, sub_d, carry_q, carry_d, neg_q, neg_d, err_q, err_d;
    logic [3:0]      op_a, op_b, dig;
    logic [4:0]      s;
    logic            bad, last;

    // Operands and result shift right one nibble per digit, so the active digit is always at [3:0].
    always_comb begin
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            bad = bad | (in_1[4*i+:4] < 4'd3) | (in_1[4*i+:4] > 4'd12)
                      | (in_2[4*i+:4] < 4'd3) | (in_2[4*i+:4] > 4'd12);
        op_a = (state_q == FIX) ? ~res_q[3:0] : a_q[3:0];
        op_b = (state_q == FIX) ? 4'd3 : b_q[3:0];
        s    = {1'b0, op_a} + {1'b0, op_b} + {4'd0, carry_q};
        dig  = s[4] ? s[3:0] + 4'd3 : s[3:0] - 4'd3;
        sh   = {dig, res_q[W-1:0]};
        last = cnt_q == CW'(DIGITS - 1);
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        sub_d   = sub_q;
        carry_d = carry_q;
        neg_d   = neg_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (in_valid) begin
                a_d     = in_1;
                b_d     = sub ? ~in_2 : in_2;
                sub_d   = sub;
                carry_d = sub;
                cnt_d   = '0;
                err_d   = bad;
                neg_d   = 1'b0;
                state_d = ADD;
            end
            ADD, FIX: begin
                a_d     = a_q >> 4;
                b_d     = b_q >> 4;
                carry_d = s[4];
                cnt_d   = cnt_q + 1'b1;
                res_d   = {res_q[W+3:W], sh[W+3:4]};
                if (last) begin
                    cnt_d = '0;
                    if (state_q == FIX || !sub_q || s[4]) begin
                        res_d[W+3:W] = (state_q == ADD && !sub_q && s[4]) ? 4'h4 : 4'h3;
                        state_d      = DONE;
                    end else begin
                        neg_d   = 1'b1;
                        carry_d = 1'b1;
                        state_d = FIX;
                    end
                end
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            neg_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            sub_q   <= sub_d;
            carry_q <= carry_d;
            neg_q   <= neg_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign out_1     = res_q;
    assign neg       = neg_q;
    assign err       = err_q;
endmodule

// File: tb/tb_e3_serial_addsub.sv
// tb_e3_serial_addsub: scoreboard bench; expected results come from decimal arithmetic on decoded XS-3 operands.
module tb_e3_serial_addsub;
    localparam int D  = 3;
    localparam int W  = 4 * D;
    localparam int OW = W + 4;

    typedef struct {
        logic [OW-1:0] r;
        logic          n;
        logic          e;
        int            lat;
        bit            full;
        longint        acc;
    } exp_t;

    logic          clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, sub = 1'b0, out_ready = 1'b1;
    logic          in_ready, out_valid, neg, err;
    logic [W-1:0]  in_1 = '0, in_2 = '0;
    logic [OW-1:0] out_1;

    exp_t          sb[$];
    exp_t          mx;
    int            n_cmp = 0, n_fail = 0;
    longint        cyc = 0;
    bit            rand_ready = 0;
    logic          pv = 1'b0;
    logic [OW-1:0] hr;
    logic          hn, he;

    e3_serial_addsub #(.DIGITS(D)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .sub(sub),
        .in_1(in_1), .in_2(in_2), .out_valid(out_valid), .out_ready(out_ready),
        .out_1(out_1), .neg(neg), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (rand_ready) out_ready = $urandom_range(0, 3) != 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        exp_t   x;
        longint av = 0, bv = 0, p = 1, r;
        logic [3:0] da, db;
        x.e = 1'b0;
        for (int i = 0; i < D; i++) begin
            da = a[4*i+:4];
            db = b[4*i+:4];
            if (da < 3 || da > 12 || db < 3 || db > 12) x.e = 1'b1;
            av += (longint'(da) - 3) * p;
            bv += (longint'(db) - 3) * p;
            p  *= 10;
        end
        r   = s ? av - bv : av + bv;
        x.n = r < 0;
        if (r < 0) r = -r;
        x.r = '0;
        for (int i = 0; i <= D; i++) begin
            x.r[4*i+:4] = 4'(r % 10 + 3);
            r /= 10;
        end
        x.lat  = x.n ? 2 * D : D;
        x.full = !x.e;
        x.acc  = 0;
        return x;
    endfunction

    function automatic logic [W-1:0] rnd_op();
        logic [W-1:0] v;
        int k;
        for (int i = 0; i < D; i++) v[4*i+:4] = 4'($urandom_range(0, 9) + 3);
        if ($urandom_range(0, 9) == 0) begin
            k = $urandom_range(0, D - 1);
            v[4*k+:4] = 4'($urandom_range(0, 15));
        end
        return v;
    endfunction

    // Called at a falling edge; returns at the falling edge after the accept edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input bit use_k, input logic [OW-1:0] kr, input logic kn, input logic ke);
        exp_t x;
        x = model(a, b, s);
        if (use_k) begin
            x.r    = kr;
            x.n    = kn;
            x.e    = ke;
            x.lat  = kn ? 2 * D : D;
            x.full = !ke;
        end
        in_1 = a;
        in_2 = b;
        sub  = s;
        in_valid = 1'b1;
        for (int t = 0; t < 200 && !in_ready; t++) @(negedge clk);
        chk("accept", in_ready, 1);
        if (in_ready) begin
            x.acc = cyc + 1;
            sb.push_back(x);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst_n) pv = 1'b0;
        else begin
            if (out_valid && !pv) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_output: got %0h expected none", out_1);
                end else begin
                    mx = sb.pop_front();
                    chk("err", err, mx.e);
                    if (mx.full) begin
                        chk("out_1", out_1, mx.r);
                        chk("neg", neg, mx.n);
                        chk("latency", cyc - mx.acc, mx.lat);
                    end
                end
                hr = out_1;
                hn = neg;
                he = err;
            end else if (out_valid) begin
                chk("hold_out_1", out_1, hr);
                chk("hold_flags", {neg, err}, {hn, he});
            end
            pv = out_valid;
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_1", out_1, 0);
        chk("rst_neg", neg, 0);
        chk("rst_err", err, 0);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);
        issue(12'h456, 12'h789, 1'b0, 1, 16'h38AC, 1'b0, 1'b0);
        issue(12'hCCC, 12'h334, 1'b0, 1, 16'h4333, 1'b0, 1'b0);
        issue(12'h789, 12'h456, 1'b1, 1, 16'h3666, 1'b0, 1'b0);
        issue(12'h456, 12'h789, 1'b1, 1, 16'h3666, 1'b1, 1'b0);
        for (int t = 0; t < 20 && !out_valid; t++) begin
            chk("in_ready_busy", in_ready, 0);
            @(negedge clk);
        end
        issue(12'h450, 12'h333, 1'b0, 1, '0, 1'b0, 1'b1);
        out_ready = 1'b0;
        for (int t = 0; t < 20 && !out_valid; t++) @(negedge clk);
        chk("bp_valid", out_valid, 1);
        repeat (5) @(negedge clk);
        chk("bp_still_valid", out_valid, 1);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_in_ready", in_ready, 1);
        chk("bp_released", out_valid, 0);
        issue(12'h456, 12'h789, 1'b0, 1, 16'h38AC, 1'b0, 1'b0);
        for (int t = 0; t < 50 && (sb.size() != 0 || !in_ready); t++) @(negedge clk);
        issue(12'hCCC, 12'h334, 1'b0, 1, 16'h4333, 1'b0, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_1", out_1, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_flags", {neg, err}, 2'b00);
        sb.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        issue(12'hCCC, 12'h334, 1'b0, 1, 16'h4333, 1'b0, 1'b0);
        rand_ready = 1;
        repeat (60) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), 0, '0, 1'b0, 1'b0);
        end
        for (int t = 0; t < 400 && sb.size() != 0; t++) @(negedge clk);
        chk("drain", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/e3_serial_addsub.md
Name: e3_serial_addsub

Overview:
- Digit-serial Excess-3 (XS-3) BCD adder/subtractor, generalised to DIGITS decimal digits.
- Processes one digit per clock, least significant digit first, and reuses a single 4-bit binary adder plus an XS-3 correction stage.
- Subtraction is by XS-3 self-complement plus carry-in 1; a negative result is re-complemented in a second serial pass, so the output is always sign + magnitude.
- Sits between operand registers and the display/accumulate path; valid/ready handshake on both sides.

Parameters:
- DIGITS, 3, number of XS-3 digits per operand (>=1).
- CW, $clog2(DIGITS) (min 1), digit counter width (localparam).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operands and mode present.
- in_ready  out  1  block can accept; =1 only in IDLE.
- sub  in  1  0: in_1+in_2; 1: in_1-in_2; sampled on accept.
- in_1  in  4*DIGITS  operand A, XS-3 digits, digit 0 at [3:0].
- in_2  in  4*DIGITS  operand B, XS-3 digits.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- out_1  out  4*DIGITS+4  result, XS-3 digits; top nibble is the carry digit.
- neg  out  1  subtract result was negative (out_1 holds magnitude).
- err  out  1  an operand digit was outside 0011..1100.

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE; out_valid=0, out_1=0, neg=0, err=0, counter=0, carry=0.
  - in_ready=1 (it is a combinational decode of IDLE).
- FSM states: IDLE, ADD, FIX, DONE.
- IDLE:
  - Accept on in_valid&&in_ready. Latch in_1, sub, and (sub ? ~in_2 : in_2).
  - Set carry=sub, counter=0, err=OR of invalid-digit checks over both raw operands, then go to ADD.
- ADD, one digit per cycle:
  - s[4:0] = a_i + b_i + carry.
  - Digit = s[4] ? s[3:0]+3 : s[3:0]-3, mod 16.
  - carry <= s[4]; digit i is written into the result register.
  - After digit DIGITS-1:
    - sub=0: top nibble = carry ? 0100 : 0011, neg=0, go to DONE.
    - sub=1 and carry=1: top nibble = 0011, neg=0, go to DONE.
    - sub=1 and carry=0: neg=1, counter=0, carry=1, go to FIX.
- FIX, one digit per cycle:
  - Operand = ~result_i, second operand = 0011 (XS-3 zero); same correction rule as ADD.
  - This yields the ten's complement, i.e. the magnitude.
  - After the last digit: top nibble = 0011, go to DONE.
- DONE: out_valid=1. out_1, neg and err are held stable until out_valid&&out_ready, then go to IDLE and clear out_valid.
- Latency: out_valid is high in the cycle after DIGITS ADD edges following the accept edge; if FIX runs, after 2*DIGITS edges. Throughput is one operation per DIGITS+2 cycles (2*DIGITS+2 with FIX) when out_ready=1.
- out_1 is updated only while in ADD or FIX; its value is undefined-but-stable outside DONE (neither bench nor implementation may rely on it).
- Invalid digits:
  - The computation still runs; err=1 is reported with the result.
  - err clears on the next accept.
- in_valid outside IDLE is ignored (no queuing). out_ready outside DONE is ignored.
- Reset asserted mid-ADD or mid-FIX aborts the operation; the result is discarded and all outputs return to reset values.
- DIGITS=1 has no FIX/ADD wrap issue: the counter compares against DIGITS-1=0.

Test Plan:
- Add 123+456: in_1=12'h456, in_2=12'h789, sub=0 -> out_1=16'h38AC, neg=0, err=0; out_valid is 3 cycles after the accept edge.
- Carry out 999+001: in_1=12'hCCC, in_2=12'h334 -> out_1=16'h4333 (1000), neg=0.
- Subtract 456-123: in_1=12'h789, in_2=12'h456, sub=1 -> out_1=16'h3666, neg=0, latency 3.
- Negative 123-456: in_1=12'h456, in_2=12'h789, sub=1 -> out_1=16'h3666, neg=1, latency 6; in_ready stays 0 throughout.
- Invalid digit plus backpressure: in_1=12'h450, in_2=12'h333 -> err=1. Hold out_ready=0 for 5 cycles: out_valid stays 1, out_1 is stable. Raise out_ready: in_ready=1 on the next cycle. A following valid op clears err.
- Reset mid-op: drop rst_n during the 2nd ADD cycle of 999+001 -> out_valid=0, out_1=0, in_ready=1 immediately. Re-issuing the op after release gives 16'h4333.
